// File: rtl/toaplan2_rom_arbiter_if.sv
// ROM arbiter bus: client CS/ADDR/OK/DOUT lanes plus
// the shared SDRAM bank slot handshake.
interface toaplan2_rom_arbiter_if #(
  parameter int CH = 4,
  parameter int AW = 22,
  parameter int DW = 32
);
  logic [CH-1:0]    CS;
  logic [CH*AW-1:0] ADDR;
  logic [CH-1:0]    OK;
  logic [CH*DW-1:0] DOUT;
  logic [AW-1:0]    BA_ADDR;
  logic             BA_RD;
  logic             BA_ACK;
  logic             BA_DOK;
  logic [15:0]      DATA_READ;
  logic             BUSY;

  modport slave (
    input  CS, ADDR, BA_ACK, BA_DOK, DATA_READ,
    output OK, DOUT, BA_ADDR, BA_RD, BUSY
  );

  modport master (
    output CS, ADDR, BA_ACK, BA_DOK, DATA_READ,
    input  OK, DOUT, BA_ADDR, BA_RD, BUSY
  );
endinterface

// File: rtl/toaplan2_rom_arbiter.sv
// Round-robin N-channel ROM read arbiter onto one SDRAM
// bank slot, with a single-entry tag cache per channel.
module toaplan2_rom_arbiter #(
  parameter int CH       = 4,
  parameter int AW       = 22,
  parameter int DW       = 32,
  parameter bit CACHE_EN = 1'b1
) (
  input logic CLK,
  input logic RESET,
  toaplan2_rom_arbiter_if.slave bus
);
  localparam int WN = DW / 16;
  localparam int KW = (WN > 1) ? $clog2(WN) : 1;
  localparam int GW = (CH > 1) ? $clog2(CH) : 1;
  localparam int SH = $clog2(WN);

  typedef enum logic [1:0] {IDLE, REQ, DATA} state_t;

  state_t        state_q, state_d;
  logic [GW-1:0] g_q, g_d;
  logic [GW-1:0] last_q, last_d;
  logic [AW-1:0] a_q, a_d;
  logic [AW-1:0] ba_addr_q, ba_addr_d;
  logic          ba_rd_q, ba_rd_d;
  logic          busy_q, busy_d;
  logic [KW-1:0] k_q, k_d;
  logic [DW-1:0] asm_q, asm_d, asm_w;
  logic [AW-1:0] tag_q [CH];
  logic [AW-1:0] tag_d [CH];
  logic [DW-1:0] dout_q [CH];
  logic [DW-1:0] dout_d [CH];
  logic [CH-1:0] valid_q, valid_d;
  logic [CH-1:0] ok, pend;
  logic          take;

  for (genvar i = 0; i < CH; i++) begin : g_ch
    assign ok[i] = bus.CS[i] & valid_q[i] &
                   (bus.ADDR[i*AW +: AW] == tag_q[i]);
    assign pend[i] = bus.CS[i] & ~ok[i] &
                     ~(busy_q && (g_q == GW'(i)));
    assign bus.DOUT[i*DW +: DW] = dout_q[i];
  end

  assign bus.OK      = ok;
  assign bus.BA_ADDR = ba_addr_q;
  assign bus.BA_RD   = ba_rd_q;
  assign bus.BUSY    = busy_q;

  // Slot the incoming 16-bit word into the assembly register.
  always_comb begin
    asm_w = asm_q;
    asm_w[16*k_q +: 16] = bus.DATA_READ;
  end

  // Grant, request handshake, word assembly and cache fill.
  always_comb begin : p_next
    int  idx;
    logic found;
    state_d   = state_q;
    g_d       = g_q;
    last_d    = last_q;
    a_d       = a_q;
    ba_addr_d = ba_addr_q;
    ba_rd_d   = ba_rd_q;
    busy_d    = busy_q;
    k_d       = k_q;
    asm_d     = asm_q;
    tag_d     = tag_q;
    dout_d    = dout_q;
    valid_d   = valid_q;
    take      = 1'b0;
    found     = 1'b0;
    idx       = 0;
    unique case (state_q)
      IDLE: begin
        for (int o = 1; o <= CH; o++) begin
          idx = (int'(last_q) + o) % CH;
          if (!found && pend[GW'(idx)]) begin
            found = 1'b1;
            g_d   = GW'(idx);
          end
        end
        if (found) begin
          a_d       = bus.ADDR[g_d*AW +: AW];
          ba_addr_d = a_d << SH;
          ba_rd_d   = 1'b1;
          busy_d    = 1'b1;
          k_d       = '0;
          state_d   = REQ;
        end
      end
      REQ: begin
        if (bus.BA_ACK) begin
          ba_rd_d = 1'b0;
          state_d = DATA;
          take    = bus.BA_DOK;
        end
      end
      DATA: take = bus.BA_DOK;
      default: state_d = IDLE;
    endcase
    if (take) begin
      asm_d = asm_w;
      if (k_q == KW'(WN - 1)) begin
        dout_d[g_q]  = asm_w;
        tag_d[g_q]   = a_q;
        valid_d[g_q] = 1'b1;
        last_d       = g_q;
        busy_d       = 1'b0;
        k_d          = '0;
        state_d      = IDLE;
      end else begin
        k_d = k_q + KW'(1);
      end
    end
    if (!CACHE_EN) begin
      for (int i = 0; i < CH; i++) begin
        if (!bus.CS[i]) valid_d[i] = 1'b0;
      end
    end
  end

  // State and cache registers with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q   <= IDLE;
      g_q       <= '0;
      last_q    <= GW'(CH - 1);
      a_q       <= '0;
      ba_addr_q <= '0;
      ba_rd_q   <= 1'b0;
      busy_q    <= 1'b0;
      k_q       <= '0;
      asm_q     <= '0;
      valid_q   <= '0;
      for (int i = 0; i < CH; i++) begin
        tag_q[i]  <= '0;
        dout_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      g_q       <= g_d;
      last_q    <= last_d;
      a_q       <= a_d;
      ba_addr_q <= ba_addr_d;
      ba_rd_q   <= ba_rd_d;
      busy_q    <= busy_d;
      k_q       <= k_d;
      asm_q     <= asm_d;
      valid_q   <= valid_d;
      tag_q     <= tag_d;
      dout_q    <= dout_d;
    end
  end
endmodule

// File: tb/tb_toaplan2_rom_arbiter.sv
// Bench for toaplan2_rom_arbiter: directed scenarios plus
// randomized traffic against a transaction-level cache model.
module tb_toaplan2_rom_arbiter;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;
  int n_cmp = 0;
  int n_bad = 0;

  toaplan2_rom_arbiter_if #(.CH(4), .AW(22), .DW(32)) ia ();
  toaplan2_rom_arbiter_if #(.CH(4), .AW(22), .DW(32)) ib ();
  toaplan2_rom_arbiter_if #(.CH(2), .AW(22), .DW(64)) ic ();

  toaplan2_rom_arbiter #(.CH(4), .AW(22), .DW(32), .CACHE_EN(1'b1))
    u_a (.CLK(clk), .RESET(rst_n), .bus(ia));
  toaplan2_rom_arbiter #(.CH(4), .AW(22), .DW(32), .CACHE_EN(1'b0))
    u_b (.CLK(clk), .RESET(rst_n), .bus(ib));
  toaplan2_rom_arbiter #(.CH(2), .AW(22), .DW(64), .CACHE_EN(1'b1))
    u_c (.CLK(clk), .RESET(rst_n), .bus(ic));

  logic [3:0]  cs_a;
  logic [21:0] addr_a [4];
  logic [3:0]  cs_b;
  logic [21:0] addr_b0;
  logic [1:0]  cs_c;
  logic [21:0] addr_c [2];
  logic [2:0]  t_ack, t_dok;
  logic [15:0] t_dat [3];
  logic [2:0]  t_rd;
  logic [21:0] t_ba [3];

  assign ia.CS = cs_a;
  assign ia.ADDR = {addr_a[3], addr_a[2], addr_a[1], addr_a[0]};
  assign ib.CS = cs_b;
  assign ib.ADDR = {66'd0, addr_b0};
  assign ic.CS = cs_c;
  assign ic.ADDR = {addr_c[1], addr_c[0]};
  assign ia.BA_ACK = t_ack[0];
  assign ib.BA_ACK = t_ack[1];
  assign ic.BA_ACK = t_ack[2];
  assign ia.BA_DOK = t_dok[0];
  assign ib.BA_DOK = t_dok[1];
  assign ic.BA_DOK = t_dok[2];
  assign ia.DATA_READ = t_dat[0];
  assign ib.DATA_READ = t_dat[1];
  assign ic.DATA_READ = t_dat[2];
  assign t_rd = {ic.BA_RD, ib.BA_RD, ia.BA_RD};
  assign t_ba[0] = ia.BA_ADDR;
  assign t_ba[1] = ib.BA_ADDR;
  assign t_ba[2] = ic.BA_ADDR;

  // reference model of DUT A's per-channel caches
  logic [3:0]  m_valid;
  logic [21:0] m_tag [4];
  logic [31:0] m_dout [4];
  int          m_last;
  int          order [$];

  function automatic logic [15:0] memw(input logic [21:0] a);
    case (a)
      22'h20:  return 16'h1234;
      22'h21:  return 16'hABCD;
      22'h0:   return 16'h1111;
      22'h1:   return 16'h2222;
      22'h2:   return 16'h3333;
      22'h3:   return 16'h4444;
      default: return 16'(a[15:0] * 16'h9E37) ^ 16'h5A5A;
    endcase
  endfunction

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    m_valid = '0;
    m_last = 3;
    for (int i = 0; i < 4; i++) begin
      m_tag[i] = '0;
      m_dout[i] = '0;
    end
  endtask

  task automatic check_a(input string tag);
    logic [3:0] eo;
    for (int i = 0; i < 4; i++)
      eo[i] = cs_a[i] && m_valid[i] && (m_tag[i] == addr_a[i]);
    check({tag, "_ok"}, 64'(ia.OK), 64'(eo));
    for (int i = 0; i < 4; i++)
      check({tag, "_dout"}, 64'(ia.DOUT[i*32 +: 32]), 64'(m_dout[i]));
  endtask

  // act as the SDRAM slot for DUT d: wait for a request, ack, return nw words
  task automatic serve(input int d, input logic [21:0] exp_ba,
                       input int nw, input int sw_ch,
                       input logic [21:0] sw_addr);
    int t;
    int w;
    t = 0;
    while (t_rd[d] !== 1'b1 && t < 30) begin
      @(negedge clk);
      t++;
    end
    check("rd_seen", 64'(t_rd[d]), 64'(1));
    if (t_rd[d] !== 1'b1) return;
    check("ba_addr", 64'(t_ba[d]), 64'(exp_ba));
    repeat ($urandom_range(0, 2)) @(negedge clk);
    check("rd_hold", 64'(t_rd[d]), 64'(1));
    check("ba_hold", 64'(t_ba[d]), 64'(exp_ba));
    t_ack[d] = 1'b1;
    w = 0;
    if ($urandom_range(0, 1) == 1) begin
      t_dok[d] = 1'b1;
      t_dat[d] = memw(exp_ba);
      w = 1;
    end
    @(negedge clk);
    t_ack[d] = 1'b0;
    t_dok[d] = 1'b0;
    check("rd_drop", 64'(t_rd[d]), 64'(0));
    if (w == 1 && sw_ch >= 0) addr_a[sw_ch] = sw_addr;
    while (w < nw) begin
      repeat ($urandom_range(0, 1)) @(negedge clk);
      t_dok[d] = 1'b1;
      t_dat[d] = memw(22'(exp_ba + 22'(w)));
      @(negedge clk);
      t_dok[d] = 1'b0;
      w++;
      if (w == 1 && sw_ch >= 0) addr_a[sw_ch] = sw_addr;
    end
  endtask

  // serve every miss on DUT A in the order the model predicts
  task automatic run_a();
    int g;
    logic [21:0] ba;
    #1;
    for (int it = 0; it < 8; it++) begin
      check_a("pre");
      g = -1;
      for (int o = 1; o <= 4; o++) begin
        int c;
        c = (m_last + o) % 4;
        if (g < 0 && cs_a[c] && !(m_valid[c] && m_tag[c] == addr_a[c]))
          g = c;
      end
      if (g < 0) break;
      order.push_back(g);
      ba = addr_a[g] << 1;
      serve(0, ba, 2, -1, 22'h0);
      m_valid[g] = 1'b1;
      m_tag[g] = addr_a[g];
      m_dout[g] = {memw(22'(ba + 22'd1)), memw(ba)};
      m_last = g;
    end
    repeat (2) @(negedge clk);
    check("idle_rd", 64'(ia.BA_RD), 64'(0));
    check("idle_busy", 64'(ia.BUSY), 64'(0));
    check_a("post");
  endtask

  initial begin
    cs_a = '0; cs_b = '0; cs_c = '0; addr_b0 = '0;
    for (int i = 0; i < 4; i++) addr_a[i] = '0;
    addr_c[0] = '0; addr_c[1] = '0;
    t_ack = '0; t_dok = '0;
    for (int i = 0; i < 3; i++) t_dat[i] = '0;
    rst_n = 1'b0;
    m_reset();
    repeat (3) @(negedge clk);
    check("rst_rd", 64'(ia.BA_RD), 64'(0));
    check("rst_busy", 64'(ia.BUSY), 64'(0));
    check("rst_ba", 64'(ia.BA_ADDR), 64'(0));
    check("rst_dout_lo", ia.DOUT[63:0], 64'(0));
    check("rst_dout_hi", ia.DOUT[127:64], 64'(0));
    rst_n = 1'b1;
    @(negedge clk);

    // single miss, one-cycle request latency
    cs_a = 4'b0001;
    addr_a[0] = 22'h10;
    @(negedge clk);
    check("lat_rd", 64'(ia.BA_RD), 64'(1));
    check("lat_busy", 64'(ia.BUSY), 64'(1));
    run_a();
    check("basic_dout", 64'(ia.DOUT[31:0]), 64'h0000_0000_ABCD_1234);
    check("basic_ok", 64'(ia.OK[0]), 64'(1));

    // cache hit after CS toggle
    cs_a = 4'b0000;
    @(negedge clk);
    check("hit_ok_low", 64'(ia.OK[0]), 64'(0));
    cs_a = 4'b0001;
    #1;
    check("hit_ok", 64'(ia.OK[0]), 64'(1));
    repeat (3) begin
      @(negedge clk);
      check("hit_no_rd", 64'(ia.BA_RD), 64'(0));
    end

    // no cache: CS toggle refetches
    cs_b = 4'b0001;
    addr_b0 = 22'h10;
    serve(1, 22'h20, 2, -1, 22'h0);
    check("b_ok", 64'(ib.OK[0]), 64'(1));
    check("b_dout", 64'(ib.DOUT[31:0]), 64'h0000_0000_ABCD_1234);
    repeat (3) @(negedge clk);
    check("b_hold_rd", 64'(ib.BA_RD), 64'(0));
    check("b_hold_ok", 64'(ib.OK[0]), 64'(1));
    cs_b = 4'b0000;
    @(negedge clk);
    check("b_ok_low", 64'(ib.OK[0]), 64'(0));
    cs_b = 4'b0001;
    serve(1, 22'h20, 2, -1, 22'h0);
    check("b_refetch_ok", 64'(ib.OK[0]), 64'(1));
    cs_b = 4'b0000;

    // 64-bit build, four words per fetch
    cs_c = 2'b01;
    addr_c[0] = 22'h0;
    serve(2, 22'h0, 4, -1, 22'h0);
    check("c_dout0", ic.DOUT[63:0], 64'h4444_3333_2222_1111);
    check("c_ok", 64'(ic.OK), 64'(2'b01));
    cs_c = 2'b11;
    addr_c[1] = 22'h1;
    serve(2, 22'h4, 4, -1, 22'h0);
    check("c_dout1", ic.DOUT[127:64],
          {memw(22'h7), memw(22'h6), memw(22'h5), memw(22'h4)});
    check("c_ok2", 64'(ic.OK), 64'(2'b11));
    check("c_dout0_kept", ic.DOUT[63:0], 64'h4444_3333_2222_1111);
    cs_c = 2'b00;

    // address changes while channel 1 is in flight
    cs_a = 4'b0010;
    addr_a[1] = 22'h100;
    #1;
    serve(0, 22'h200, 2, 1, 22'h200);
    m_valid[1] = 1'b1;
    m_tag[1] = 22'h100;
    m_dout[1] = {memw(22'h201), memw(22'h200)};
    m_last = 1;
    check("swap_ok_low", 64'(ia.OK[1]), 64'(0));
    check_a("swap");
    run_a();
    check("swap_refill_ok", 64'(ia.OK[1]), 64'(1));

    // reset in the middle of DATA
    cs_a = 4'b0100;
    addr_a[2] = 22'h300;
    @(negedge clk);
    check("rr_rd", 64'(ia.BA_RD), 64'(1));
    t_ack[0] = 1'b1;
    @(negedge clk);
    t_ack[0] = 1'b0;
    t_dok[0] = 1'b1;
    t_dat[0] = 16'h7777;
    @(negedge clk);
    t_dok[0] = 1'b0;
    check("rr_busy_mid", 64'(ia.BUSY), 64'(1));
    rst_n = 1'b0;
    @(negedge clk);
    check("rr_rd_low", 64'(ia.BA_RD), 64'(0));
    check("rr_busy_low", 64'(ia.BUSY), 64'(0));
    check("rr_ok_low", 64'(ia.OK), 64'(0));
    cs_a = 4'b0000;
    t_dok[0] = 1'b1;
    @(negedge clk);
    t_dok[0] = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    t_ack[0] = 1'b1;
    t_dok[0] = 1'b1;
    t_dat[0] = 16'hFFFF;
    @(negedge clk);
    t_ack[0] = 1'b0;
    t_dok[0] = 1'b0;
    @(negedge clk);
    check("stray_dout_lo", ia.DOUT[63:0], 64'(0));
    check("stray_dout_hi", ia.DOUT[127:64], 64'(0));
    check("stray_rd", 64'(ia.BA_RD), 64'(0));
    check("stray_busy", 64'(ia.BUSY), 64'(0));
    m_reset();

    // all four miss together: order 0..3, twice
    for (int r = 0; r < 2; r++) begin
      order.delete();
      cs_a = 4'b1111;
      for (int i = 0; i < 4; i++) addr_a[i] = 22'(22'h40 + 16*r + i);
      run_a();
      check("order_n", 64'(order.size()), 64'(4));
      for (int i = 0; i < 4; i++)
        check("order", 64'(order[i]), 64'(i));
    end

    // randomized traffic
    for (int s = 0; s < 40; s++) begin
      for (int i = 0; i < 4; i++) begin
        cs_a[i] = ($urandom_range(0, 3) != 0);
        addr_a[i] = 22'(i * 16 + $urandom_range(0, 3));
      end
      run_a();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
